key_repeat: RTL and testbench

- Sits directly downstream of the per-key debouncer in the maze input path.
- Consumes the debounced level of each direction key and emits single-cycle move commands with a direction code.
- Each fresh press gives one immediate move. Holding the key gives auto-repeat moves after an initial hold delay.
- Feeds the maze position/game-logic block, which acts only on move_pulse.

---
 rtl/key_pkg.sv | 30 +++
 rtl/key_edge_detect.sv | 33 +++
 rtl/key_repeat.sv | 139 +++++++++++++
 tb/tb_key_repeat.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// ============================================================================
// Module  : key_pkg
// Purpose : Shared state encoding, direction codes and default timing for
//           the key auto-repeat block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam int c_DIR_UP    = 0;
    localparam int c_DIR_DOWN  = 1;
    localparam int c_DIR_LEFT  = 2;
    localparam int c_DIR_RIGHT = 3;

    // 50 cycles per ms at simulation scale
    localparam int c_KEYS_DEFAULT       = 4;
    localparam int c_DELAY_CYC_DEFAULT  = 1500;
    localparam int c_REPEAT_CYC_DEFAULT = 500;
    localparam int c_CNT_W_DEFAULT      = 16;

endpackage

`default_nettype wire

// File: rtl/key_edge_detect.sv
// ============================================================================
// Module  : key_edge_detect
// Purpose : Rising-edge detector for debounced key levels. Keys held through
//           reset do not produce a rise until released and pressed again.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_edge_detect #(
    parameter int KEYS = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [KEYS-1:0] key_in,
    output logic [KEYS-1:0] rise
);

    logic [KEYS-1:0] r_key_prev;

    // All-ones reset masks any key already down when reset releases
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_key_prev <= '1;
        end else begin
            r_key_prev <= key_in;
        end
    end

    assign rise = key_in & ~r_key_prev;

endmodule

`default_nettype wire

// File: rtl/key_repeat.sv
// ============================================================================
// Module  : key_repeat
// Purpose : Turns debounced direction keys into single-cycle move strobes
//           with an immediate move on press and auto-repeat while held.
//           Optional macro KEY_RELEASE_EN adds a release_pulse output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_repeat
    import key_pkg::*;
#(
    parameter  int KEYS       = c_KEYS_DEFAULT,
    parameter  int DELAY_CYC  = c_DELAY_CYC_DEFAULT,
    parameter  int REPEAT_CYC = c_REPEAT_CYC_DEFAULT,
    parameter  int CNT_W      = c_CNT_W_DEFAULT,
    localparam int DIR_W      = (KEYS > 1) ? $clog2(KEYS) : 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [KEYS-1:0]  key_in,
    output logic             move_pulse,
    output logic [DIR_W-1:0] move_dir,
`ifdef KEY_RELEASE_EN
    output logic             release_pulse,
`endif
    output logic             key_held
);

    localparam logic [CNT_W-1:0] c_DELAY_LAST  = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    logic [KEYS-1:0]  w_rise;
    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [DIR_W-1:0] r_lock,   w_lock_nxt;
    logic [DIR_W-1:0] w_enc;
    logic [DIR_W-1:0] w_dir_nxt;
    logic             w_pulse_nxt;
    logic             w_rel_nxt;
    logic             w_lock_lvl;

    key_edge_detect #(
        .KEYS   (KEYS)
    ) u_edge (
        .clk    (clk),
        .nrst   (nrst),
        .key_in (key_in),
        .rise   (w_rise)
    );

    // Lowest index wins when several keys rise together
    always_comb begin
        w_enc = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (w_rise[i]) begin
                w_enc = DIR_W'(i);
            end
        end
    end

    assign w_lock_lvl = key_in[r_lock];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lock_nxt  = r_lock;
        w_dir_nxt   = move_dir;
        w_pulse_nxt = 1'b0;
        w_rel_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_rise) begin
                    w_lock_nxt  = w_enc;
                    w_dir_nxt   = w_enc;
                    w_pulse_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // Release takes priority over a terminal count
                if (!w_lock_lvl) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_rel_nxt   = 1'b1;
`ifdef KEY_RELEASE_EN
                    w_dir_nxt   = r_lock;
`endif
                end else if (r_cnt == ((r_state == ST_HOLD) ? c_DELAY_LAST : c_REPEAT_LAST)) begin
                    w_pulse_nxt = 1'b1;
                    w_dir_nxt   = r_lock;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_REPEAT;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_lock     <= '0;
            move_pulse <= 1'b0;
            move_dir   <= '0;
            key_held   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lock     <= w_lock_nxt;
            move_pulse <= w_pulse_nxt;
            move_dir   <= w_dir_nxt;
            key_held   <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef KEY_RELEASE_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            release_pulse <= 1'b0;
        end else begin
            release_pulse <= w_rel_nxt;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_rel_nxt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_repeat.sv
// ============================================================================
// Module  : tb_key_repeat
// Purpose : Self-checking bench for key_repeat with a timeline-based model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_repeat;

    localparam int KEYS  = 4;
    localparam int DELAY = 10;
    localparam int REP   = 4;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] key_in;
    logic       move_pulse;
    logic [1:0] move_dir;
    logic       key_held;
`ifdef KEY_RELEASE_EN
    logic       release_pulse;
`endif

    always #5 clk = ~clk;

    key_repeat #(
        .KEYS          (KEYS),
        .DELAY_CYC     (DELAY),
        .REPEAT_CYC    (REP),
        .CNT_W         (16)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .key_in        (key_in),
        .move_pulse    (move_pulse),
        .move_dir      (move_dir),
`ifdef KEY_RELEASE_EN
        .release_pulse (release_pulse),
`endif
        .key_held      (key_held)
    );

    int errors = 0;
    int checks = 0;

    // Model: a press at cycle t0 fires at t0, t0+DELAY, t0+DELAY+n*REP while held
    bit         m_locked;
    int         m_lk;
    int         m_t0;
    int         m_t;
    logic [3:0] m_prev;
    bit         e_pulse;
    bit         e_rel;
    int         e_dir;

    int pulse_cnt;
    int dir_cnt [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_prev   = '1;
        m_t      = 0;
        m_t0     = 0;
        m_lk     = 0;
    endtask

    task automatic model_edge(input logic [3:0] k);
        logic [3:0] rise;
        int d;
        rise    = k & ~m_prev;
        e_pulse = 1'b0;
        e_rel   = 1'b0;
        if (!m_locked) begin
            if (rise != 4'b0) begin
                for (int i = KEYS - 1; i >= 0; i--) begin
                    if (rise[i]) m_lk = i;
                end
                m_locked = 1'b1;
                m_t0     = m_t;
                e_pulse  = 1'b1;
                e_dir    = m_lk;
            end
        end else if (!k[m_lk]) begin
            m_locked = 1'b0;
            e_rel    = 1'b1;
            e_dir    = m_lk;
        end else begin
            d = m_t - m_t0;
            if (d >= DELAY && ((d - DELAY) % REP) == 0) begin
                e_pulse = 1'b1;
                e_dir   = m_lk;
            end
        end
        m_prev = k;
        m_t++;
    endtask

    task automatic step(input logic [3:0] k);
        key_in = k;
        @(posedge clk);
        model_edge(k);
        #1;
        chk("move_pulse", 32'(move_pulse), 32'(e_pulse));
        chk("key_held", 32'(key_held), 32'(m_locked));
        if (e_pulse) chk("move_dir", 32'(move_dir), 32'(e_dir));
`ifdef KEY_RELEASE_EN
        chk("release_pulse", 32'(release_pulse), 32'(e_rel));
        if (e_rel) chk("release_dir", 32'(move_dir), 32'(e_dir));
`endif
        if (move_pulse === 1'b1) begin
            pulse_cnt++;
            dir_cnt[move_dir]++;
        end
    endtask

    task automatic hold(input logic [3:0] k, input int n);
        repeat (n) step(k);
    endtask

    task automatic clear_counts();
        pulse_cnt = 0;
        for (int i = 0; i < 4; i++) dir_cnt[i] = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pulse"}, 32'(move_pulse), 32'd0);
        chk({tag, "_dir"}, 32'(move_dir), 32'd0);
        chk({tag, "_held"}, 32'(key_held), 32'd0);
`ifdef KEY_RELEASE_EN
        chk({tag, "_rel"}, 32'(release_pulse), 32'd0);
`endif
    endtask

    initial begin
        logic [3:0] cur;
        key_in = 4'b0;
        nrst   = 1'b0;
        model_reset();
        clear_counts();
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        nrst = 1'b1;
        hold(4'b0000, 3);

        // Tap
        clear_counts();
        hold(4'b0001, 5);
        hold(4'b0000, 3);
        chk("tap_count", 32'(pulse_cnt), 32'd1);
        chk("tap_dir0", 32'(dir_cnt[0]), 32'd1);

        // Hold: pulses at relative 0,10,14,18,22,26
        clear_counts();
        hold(4'b0100, 30);
        hold(4'b0000, 5);
        chk("hold_count", 32'(pulse_cnt), 32'd6);
        chk("hold_dir2", 32'(dir_cnt[2]), 32'd6);

        // Simultaneous press: lowest index wins, key 3 never fires
        clear_counts();
        hold(4'b1010, 3);
        hold(4'b1000, 6);
        hold(4'b0000, 2);
        chk("simul_count", 32'(pulse_cnt), 32'd1);
        chk("simul_dir1", 32'(dir_cnt[1]), 32'd1);
        chk("simul_dir3", 32'(dir_cnt[3]), 32'd0);

        // Other keys ignored while locked
        clear_counts();
        hold(4'b0001, 3);
        hold(4'b0011, 17);
        hold(4'b0000, 2);
        chk("lock_count", 32'(pulse_cnt), 32'd4);
        chk("lock_dir1", 32'(dir_cnt[1]), 32'd0);

        // Release exactly at the delay terminal count
        clear_counts();
        hold(4'b0001, DELAY);
        step(4'b0000);
        chk("bound_count", 32'(pulse_cnt), 32'd1);
        chk("bound_held", 32'(key_held), 32'd0);
        hold(4'b0000, 2);

        // Async reset mid-REPEAT with key still held
        clear_counts();
        hold(4'b1000, 16);
        nrst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("inreset");
        nrst = 1'b1;
        model_reset();
        clear_counts();
        hold(4'b1000, 5);
        chk("after_reset_held_count", 32'(pulse_cnt), 32'd0);
        hold(4'b0000, 2);
        hold(4'b1000, 3);
        step(4'b0000);
        chk("repress_count", 32'(pulse_cnt), 32'd1);
        chk("repress_dir3", 32'(dir_cnt[3]), 32'd1);

        // Random key activity, long dwell times so repeats occur
        cur = 4'b0;
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) cur = 4'($urandom_range(0, 15));
            step(cur);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
